// File: rtl/codec_pkg.sv
// Shared definitions for the codec frame controller.
// State encoding and default frame timing constants.
package codec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TAIL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_FRAME_LEN   = 16;
    localparam int DEF_TAIL_LEN    = 2;
    localparam int DEF_DEC_LATENCY = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/codec_tag_delay.sv
// Fixed-depth shift register carrying the payload tag
// alongside the decoder pipeline.
module codec_tag_delay #(
    parameter int DEPTH = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift one position per cycle, new tag enters at bit 0
    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // Tag storage, cleared on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/codec_frame_controller.sv
// Frame sequencer around a K=3 encoder / Viterbi decoder pair:
// load payload, flush the trellis, drain the decoder, pulse done.
module codec_frame_controller
    import codec_pkg::*;
#(
    parameter int FRAME_LEN   = DEF_FRAME_LEN,
    parameter int TAIL_LEN    = DEF_TAIL_LEN,
    parameter int DEC_LATENCY = DEF_DEC_LATENCY
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic start,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    output logic enc_in,
    input  logic dec_out,
    output logic out_bit,
    output logic out_valid,
    output logic busy,
    output logic frame_done,
    output logic underrun
);

    localparam int CW =
        $clog2(max3(FRAME_LEN, TAIL_LEN, DEC_LATENCY) + 1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TAIL_LAST  = CW'(TAIL_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DEC_LATENCY - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          underrun_q, underrun_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          load_w;
    logic          tag_in;
    logic          tag_out;

    // Next-state, slot counter and sticky underrun
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        underrun_d = underrun_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d    = ST_LOAD;
                    underrun_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!in_valid) underrun_d = 1'b1;
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (TAIL_LEN > 0) ? ST_TAIL : ST_DRAIN;
                end
            end
            ST_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_LOAD);
    end

    // FSM state plus registered status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign load_w = (state_q == ST_LOAD);
    assign tag_in = load_w & in_valid;

    codec_tag_delay #(
        .DEPTH (DEC_LATENCY)
    ) u_tag (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (tag_in),
        .q     (tag_out)
    );

    assign enc_in     = load_w & in_valid & in_bit;
    assign in_ready   = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign underrun   = underrun_q;
    assign out_valid  = tag_out;
    assign out_bit    = tag_out & dec_out;

endmodule

// File: tb/tb_codec_frame_controller.sv
// Directed bench for codec_frame_controller with an ideal
// fixed-latency decoder model closing the loop.
module tb_codec_frame_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    logic st_a = 0, ib_a = 0, iv_a = 0;
    logic ir_a, ei_a, dout_a, ob_a, ov_a, busy_a, fd_a, ur_a;
    logic st_b = 0, ib_b = 0, iv_b = 0;
    logic ir_b, ei_b, dout_b, ob_b, ov_b, busy_b, fd_b, ur_b;

    logic [7:0] dla = '0;
    logic [7:0] dlb = '0;

    int n_chk = 0;
    int n_err = 0;

    int          na, nb, dca, dcb, dfa, dla_c, dfb;
    logic [31:0] ga, gb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal decoder: returns the encoder input 8 cycles later
    always @(posedge clk) begin
        dla <= {dla[6:0], ei_a};
        dlb <= {dlb[6:0], ei_b};
    end
    assign dout_a = dla[7];
    assign dout_b = dlb[7];

    codec_frame_controller #(
        .FRAME_LEN(16), .TAIL_LEN(2), .DEC_LATENCY(8)
    ) dut_a (
        .CLK(clk), .RST_N(rst_n), .start(st_a),
        .in_bit(ib_a), .in_valid(iv_a), .in_ready(ir_a),
        .enc_in(ei_a), .dec_out(dout_a), .out_bit(ob_a),
        .out_valid(ov_a), .busy(busy_a),
        .frame_done(fd_a), .underrun(ur_a)
    );

    codec_frame_controller #(
        .FRAME_LEN(1), .TAIL_LEN(2), .DEC_LATENCY(8)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n), .start(st_b),
        .in_bit(ib_b), .in_valid(iv_b), .in_ready(ir_b),
        .enc_in(ei_b), .dec_out(dout_b), .out_bit(ob_b),
        .out_valid(ov_b), .busy(busy_b),
        .frame_done(fd_b), .underrun(ur_b)
    );

    // Output collection away from the active edge
    always @(negedge clk) begin
        if (ov_a) begin
            ga = {ga[30:0], ob_a};
            na++;
        end
        if (fd_a) begin
            if (dca == 0) dfa = cyc;
            dla_c = cyc;
            dca++;
        end
        if (ov_b) begin
            gb = {gb[30:0], ob_b};
            nb++;
        end
        if (fd_b) begin
            if (dcb == 0) dfb = cyc;
            dcb++;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        na = 0; nb = 0; dca = 0; dcb = 0;
        dfa = 0; dla_c = 0; dfb = 0;
        ga = '0; gb = '0;
    endtask

    // One 16-bit frame on dut_a; poke raises start in LOAD, TAIL, DONE
    task automatic run_frame(input logic [15:0] pay,
                             input int drop,
                             input bit poke,
                             output int n0);
        st_a = 1; n0 = cyc; tick(); st_a = 0;
        for (int k = 0; k < 16; k++) begin
            ib_a = pay[15-k];
            iv_a = (k != drop);
            st_a = poke && (k == 3);
            #1;
            if (k == 0) begin
                chk("ready_load", ir_a, 1);
                chk("underrun_clr", ur_a, 0);
                chk("busy_load", busy_a, 1);
            end
            chk("enc_in", ei_a, (k != drop) & pay[15-k]);
            tick();
        end
        ib_a = 0; iv_a = 0; st_a = poke;
        #1;
        chk("ready_tail", ir_a, 0);
        tick(); st_a = 0;
        while (cyc < n0 + 27) tick();
        st_a = poke; tick(); st_a = 0;
    endtask

    int n0, n1;

    initial begin
        clr();
        repeat (3) tick();
        chk("rst_ready", ir_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", fd_a, 0);
        chk("rst_ovalid", ov_a, 0);
        chk("rst_underrun", ur_a, 0);
        chk("rst_enc", ei_a, 0);
        rst_n = 1;
        tick();

        // Clean frame
        clr();
        run_frame(16'hA5C3, -1, 0, n0);
        tick(); tick();
        chk("f1_count", na, 16);
        chk("f1_bits", ga, 32'hA5C3);
        chk("f1_done_cnt", dca, 1);
        chk("f1_done_lat", dfa - n0, 27);
        chk("f1_underrun", ur_a, 0);
        chk("f1_idle", busy_a, 0);

        // Slot 5 missing
        clr();
        run_frame(16'hA5C3, 5, 0, n0);
        tick();
        chk("f2_underrun", ur_a, 1);
        chk("f2_count", na, 15);
        chk("f2_bits", ga, 32'h51C3);
        chk("f2_done_cnt", dca, 1);

        // Stray start in LOAD, TAIL and DONE
        clr();
        run_frame(16'h1234, -1, 1, n0);
        repeat (4) tick();
        chk("f3_done_cnt", dca, 1);
        chk("f3_done_lat", dfa - n0, 27);
        chk("f3_count", na, 16);
        chk("f3_bits", ga, 32'h1234);
        chk("f3_idle", busy_a, 0);

        // Reset at LOAD slot 7
        clr();
        st_a = 1; n0 = cyc; tick(); st_a = 0;
        for (int k = 0; k < 7; k++) begin
            ib_a = 1; iv_a = (k != 2);
            tick();
        end
        ib_a = 1; iv_a = 1;
        #1;
        chk("f4_pre_underrun", ur_a, 1);
        chk("f4_pre_enc", ei_a, 1);
        #1 rst_n = 0;
        #1;
        chk("f4_rst_enc", ei_a, 0);
        chk("f4_rst_ready", ir_a, 0);
        chk("f4_rst_busy", busy_a, 0);
        chk("f4_rst_underrun", ur_a, 0);
        chk("f4_rst_ov", {ov_a, ob_a, fd_a}, 0);
        ib_a = 0; iv_a = 0;
        tick(); tick();
        rst_n = 1;
        repeat (12) tick();
        chk("f4_no_done", dca, 0);
        chk("f4_no_out", na, 0);
        clr();
        run_frame(16'h0F0F, -1, 0, n0);
        tick();
        chk("f4_next_bits", ga, 32'h0F0F);
        chk("f4_next_done", dca, 1);

        // Back-to-back frames
        clr();
        run_frame(16'hBEEF, -1, 0, n0);
        run_frame(16'h0137, -1, 0, n1);
        tick(); tick();
        chk("b2b_done_cnt", dca, 2);
        chk("b2b_gap", dla_c - dfa, 28);
        chk("b2b_start_gap", n1 - n0, 28);
        chk("b2b_count", na, 32);
        chk("b2b_bits", ga, 32'hBEEF0137);

        // Single-bit frame on dut_b
        clr();
        st_b = 1; n0 = cyc; tick(); st_b = 0;
        ib_b = 1; iv_b = 1;
        #1;
        chk("fl1_ready", ir_b, 1);
        tick();
        ib_b = 0; iv_b = 0;
        repeat (14) tick();
        chk("fl1_count", nb, 1);
        chk("fl1_bit", gb, 1);
        chk("fl1_done_cnt", dcb, 1);
        chk("fl1_done_lat", dfb - n0, 12);
        chk("fl1_idle", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/codec_frame_controller.md
CODEC_FRAME_CONTROLLER -- requirements
Module: codec_frame_controller

Interface
REQ-001 Parameter FRAME_LEN, default 16, number of payload bits per frame (>=1).
REQ-002 Parameter TAIL_LEN, default 2, zero tail bits that flush the K=3 encoder to state 0.
REQ-003 Parameter DEC_LATENCY, default 8, cycles from an encoder input bit to its decoded bit at dec_out (>=1).
REQ-004 CLK  input  1  single system clock; all state updates on posedge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a frame.
REQ-007 in_bit  input  1  payload bit from the source.
REQ-008 in_valid  input  1  in_bit is valid this cycle.
REQ-009 in_ready  output  1  controller consumes in_bit this cycle.
REQ-010 enc_in  output  1  bit driven to the convolutional encoder input.
REQ-011 dec_out  input  1  bit from the Viterbi decoder output.
REQ-012 out_bit  output  1  recovered payload bit.
REQ-013 out_valid  output  1  out_bit is a payload bit.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse at frame completion.
REQ-016 underrun  output  1  sticky: a LOAD cycle had in_valid low.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, TAIL, DRAIN, DONE.
REQ-018 IDLE->LOAD on start; start in any other state SHALL be ignored.
REQ-019 LOAD SHALL last exactly FRAME_LEN cycles; in_ready=1; enc_in=in_bit if in_valid else 0.
REQ-020 A LOAD cycle with in_valid=0 SHALL set underrun and tag that slot non-payload; the frame continues (no stall, encoder runs every cycle).
REQ-021 LOAD->TAIL after FRAME_LEN cycles; TAIL SHALL drive enc_in=0 for exactly TAIL_LEN cycles, tagged non-payload.
REQ-022 TAIL->DRAIN; DRAIN SHALL last DEC_LATENCY cycles with enc_in=0, tagged non-payload.
REQ-023 DRAIN->DONE; DONE SHALL last one cycle with frame_done=1, then ->IDLE.
REQ-024 A DEC_LATENCY-deep tag shift register SHALL advance every cycle; out_valid = tag emerging this cycle; out_bit = dec_out registered-free passthrough aligned to that tag.
REQ-025 Consequently out_valid SHALL be high exactly DEC_LATENCY cycles after each valid LOAD cycle, count = FRAME_LEN minus underrun slots.
REQ-026 Outside LOAD: in_ready=0, enc_in=0.
REQ-027 Slot counter SHALL be clog2(max(FRAME_LEN,TAIL_LEN,DEC_LATENCY)+1) bits, cleared on each state entry, no wrap.
REQ-028 underrun SHALL clear on the cycle start is accepted in IDLE.
REQ-029 start coincident with DONE SHALL be ignored; a new frame requires start in IDLE.

Reset
REQ-030 RST_N low SHALL immediately force IDLE, clear counters and tag register, and drive in_ready=0, enc_in=0, out_valid=0, out_bit=0, busy=0, frame_done=0, underrun=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no frame_done; encoder/decoder state is not repaired (next frame starts from whatever trellis state remains).

Structure
REQ-032 FSM state encoding and default TAIL_LEN/DEC_LATENCY constants SHALL live in a shared package codec_pkg.
REQ-033 Tag delay line SHALL be a sub-module codec_tag_delay (parameter DEPTH, ports CLK, RST_N, d, q).
REQ-034 System-level wrapper SHALL connect enc_in to the encoder input and decoder output to dec_out.

Verification
REQ-035 FRAME_LEN=16, in_valid=1 throughout, payload 0xA5C3 MSB first -> 16 out_valid pulses, out_bit = 0xA5C3, frame_done once 16+2+8+1 cycles after start.
REQ-036 in_valid low on LOAD slot 5 -> underrun=1, 15 out_valid pulses, slot 5 missing; underrun clears on next start.
REQ-037 start asserted during LOAD, TAIL and DONE -> no effect, single frame_done.
REQ-038 RST_N low at LOAD slot 7 -> all outputs 0 within same cycle, IDLE, no frame_done; next frame after reset decodes correctly once trellis flushed.
REQ-039 Back-to-back frames, start in IDLE cycle right after DONE -> both frames decoded, two frame_done pulses 28 cycles apart.
REQ-040 FRAME_LEN=1 -> one out_valid pulse, frame_done 12 cycles after start.
